// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int DMEM_DEPTH = 65536;

endpackage

// File: rtl/dmem_rtag_pipe.sv
// One-deep read tag: remembers who issued the read and steers the memory
// read data back to that owner one cycle later.
module dmem_rtag_pipe
  import dmem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          issue_l,
  input  logic [DW-1:0] mem_rdata,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata
);

  logic  valid_q;
  port_t owner_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      owner_q <= PORT_L;
    end else begin
      valid_q <= issue;
      owner_q <= issue_l ? PORT_L : PORT_C;
    end
  end

  assign c_rvalid = valid_q & (owner_q == PORT_C);
  assign l_rvalid = valid_q & (owner_q == PORT_L);
  assign c_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory with bounded port-L lock.
// Define DMEM_ARB_RR_EN for round-robin on unlocked contention (default: port C wins).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_stall,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  lock_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked, contention, forced;

  assign locked     = (state_q == LOCKED);
  assign contention = c_req & l_req;
  // Forced release hands the contested cycle to C, so L cannot relock in it.
  assign forced     = locked & contention & (cnt_q == CNT_LAST);

`ifdef DMEM_ARB_RR_EN
  port_t last_owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_owner_q <= PORT_L;
    else if (c_gnt) last_owner_q <= PORT_C;
    else if (l_gnt) last_owner_q <= PORT_L;
  end
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (contention) begin
      if (locked) begin
        c_gnt = forced;
        l_gnt = ~forced;
      end else begin
`ifdef DMEM_ARB_RR_EN
        c_gnt = (last_owner_q == PORT_L);
        l_gnt = (last_owner_q == PORT_C);
`else
        c_gnt = 1'b1;
`endif
      end
    end else begin
      c_gnt = c_req;
      l_gnt = l_req;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (l_gnt && l_lock) state_d = LOCKED;
      end
      LOCKED: begin
        if (!l_lock || !l_req || forced) begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(c_req);
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign c_stall   = c_req & ~c_gnt;
  assign mem_r     = (c_gnt & ~c_we) | (l_gnt & ~l_we);
  assign mem_w     = (c_gnt & c_we) | (l_gnt & l_we);
  assign mem_addr  = l_gnt ? l_addr : c_addr;
  assign mem_wdata = l_gnt ? l_wdata : c_wdata;

  dmem_rtag_pipe #(.DW(DW)) u_rtag (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (mem_r),
    .issue_l   (l_gnt),
    .mem_rdata (mem_rdata),
    .c_rvalid  (c_rvalid),
    .c_rdata   (c_rdata),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table plus lock-burst and reset sequences.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk, rst_n;
  logic        c_req, c_we, c_gnt, c_stall, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_r, mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [DMEM_DEPTH];
  always @(posedge clk) begin
    if (mem_w) mem[mem_addr[15:0]] <= mem_wdata;
    if (mem_r) mem_rdata <= mem[mem_addr[15:0]];
  end

  typedef struct packed {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        lr, lw;
    logic [31:0] la, ld;
    logic        lk;
    logic        ecg, elg, ecs, emr, emw;
    logic [31:0] ema;
    logic        ecrv, elrv;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic lk);
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld; l_lock = lk;
  endtask

  task automatic c_read(input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    drive(1, 0, addr, 0, 0, 0, 0, 0, 0);
    #1 check($sformatf("c_read_gnt@%h", addr), {31'b0, c_gnt}, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check($sformatf("c_read_rvalid@%h", addr), {31'b0, c_rvalid}, 1);
    check($sformatf("c_read_data@%h", addr), c_rdata, exp);
  endtask

  int  l_idx;
  logic c_done, c_act, e_cg, e_lg, prev_l, prev_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //        cr cw ca      cd       lr lw la      ld        lk  cg lg cs mr mw ma      crv lrv rd
    vecs[0]  = '{0, 0, 32'h0,  32'h0,   0, 0, 32'h0,  32'h0,    0,  0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0};
    vecs[1]  = '{0, 0, 32'h0,  32'h0,   1, 1, 32'h10, 32'hCAFE, 0,  0, 1, 0, 0, 1, 32'h10, 0, 0, 32'h0};
    vecs[2]  = '{0, 0, 32'h0,  32'h0,   1, 1, 32'h40, 32'h1234, 0,  0, 1, 0, 0, 1, 32'h40, 0, 0, 32'h0};
    vecs[3]  = '{1, 0, 32'h10, 32'h0,   0, 0, 32'h0,  32'h0,    0,  1, 0, 0, 1, 0, 32'h10, 0, 0, 32'h0};
    vecs[4]  = '{0, 0, 32'h0,  32'h0,   1, 0, 32'h40, 32'h0,    0,  0, 1, 0, 1, 0, 32'h40, 1, 0, 32'hCAFE};
    vecs[5]  = '{1, 0, 32'h40, 32'h0,   1, 0, 32'h10, 32'h0,    0,  1, 0, 0, 1, 0, 32'h40, 0, 1, 32'h1234};
    vecs[6]  = '{0, 0, 32'h0,  32'h0,   1, 0, 32'h10, 32'h0,    0,  0, 1, 0, 1, 0, 32'h10, 1, 0, 32'h1234};
    vecs[7]  = '{0, 0, 32'h0,  32'h0,   0, 0, 32'h0,  32'h0,    0,  0, 0, 0, 0, 0, 32'h0,  0, 1, 32'hCAFE};
    vecs[8]  = '{0, 0, 32'h0,  32'h0,   1, 1, 32'h20, 32'h55,   0,  0, 1, 0, 0, 1, 32'h20, 0, 0, 32'h0};
    vecs[9]  = '{1, 0, 32'h20, 32'h0,   0, 0, 32'h0,  32'h0,    0,  1, 0, 0, 1, 0, 32'h20, 0, 0, 32'h0};
    vecs[10] = '{0, 0, 32'h0,  32'h0,   1, 1, 32'h70, 32'h99,   0,  0, 1, 0, 0, 1, 32'h70, 1, 0, 32'h55};
    vecs[11] = '{1, 1, 32'h50, 32'hA,   1, 1, 32'h60, 32'hB,    0,  1, 0, 0, 0, 1, 32'h50, 0, 0, 32'h0};
    vecs[12] = '{0, 0, 32'h0,  32'h0,   1, 1, 32'h60, 32'hB,    0,  0, 1, 0, 0, 1, 32'h60, 0, 0, 32'h0};
    vecs[13] = '{1, 0, 32'h50, 32'h0,   0, 0, 32'h0,  32'h0,    0,  1, 0, 0, 1, 0, 32'h50, 0, 0, 32'h0};
    vecs[14] = '{0, 0, 32'h0,  32'h0,   1, 0, 32'h60, 32'h0,    0,  0, 1, 0, 1, 0, 32'h60, 1, 0, 32'hA};
    vecs[15] = '{0, 0, 32'h0,  32'h0,   0, 0, 32'h0,  32'h0,    0,  0, 0, 0, 0, 0, 32'h0,  0, 1, 32'hB};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
            vecs[i].lr, vecs[i].lw, vecs[i].la, vecs[i].ld, vecs[i].lk);
      #1;
      check($sformatf("v%0d c_gnt", i),    {31'b0, c_gnt},    {31'b0, vecs[i].ecg});
      check($sformatf("v%0d l_gnt", i),    {31'b0, l_gnt},    {31'b0, vecs[i].elg});
      check($sformatf("v%0d c_stall", i),  {31'b0, c_stall},  {31'b0, vecs[i].ecs});
      check($sformatf("v%0d mem_r", i),    {31'b0, mem_r},    {31'b0, vecs[i].emr});
      check($sformatf("v%0d mem_w", i),    {31'b0, mem_w},    {31'b0, vecs[i].emw});
      check($sformatf("v%0d c_rvalid", i), {31'b0, c_rvalid}, {31'b0, vecs[i].ecrv});
      check($sformatf("v%0d l_rvalid", i), {31'b0, l_rvalid}, {31'b0, vecs[i].elrv});
      if (vecs[i].emr || vecs[i].emw)
        check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].ema);
      if (vecs[i].emw)
        check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].lw && vecs[i].elg ? vecs[i].ld : vecs[i].cd);
      if (vecs[i].ecrv) check($sformatf("v%0d c_rdata", i), c_rdata, vecs[i].erd);
      if (vecs[i].elrv) check($sformatf("v%0d l_rdata", i), l_rdata, vecs[i].erd);
    end

    // Locked burst of 20 writes; C starts a read at cycle 3 and is forced in at cycle 10.
    l_idx  = 0;
    c_done = 1'b0;
    for (int cyc = 0; cyc < 40 && l_idx < 20; cyc++) begin
      @(negedge clk);
      c_act = (cyc >= 3) && !c_done;
      drive(c_act, 0, 32'h10, 0, 1, 1, 32'h100 + l_idx, l_idx, 1);
      e_cg = c_act && (cyc == 10);
      e_lg = !e_cg;
      #1;
      check($sformatf("lock%0d c_gnt", cyc),    {31'b0, c_gnt},    {31'b0, e_cg});
      check($sformatf("lock%0d l_gnt", cyc),    {31'b0, l_gnt},    {31'b0, e_lg});
      check($sformatf("lock%0d c_stall", cyc),  {31'b0, c_stall},  {31'b0, c_act && !e_cg});
      check($sformatf("lock%0d c_rvalid", cyc), {31'b0, c_rvalid}, {31'b0, cyc == 11});
      if (cyc == 11) check("lock c_rdata", c_rdata, 32'hCAFE);
      if (e_cg) c_done = 1'b1;
      if (e_lg) l_idx++;
    end
    check("lock burst c served", {31'b0, c_done}, 1);
    c_read(32'h109, 32'd9);
    c_read(32'h113, 32'd19);

    // Reset in the middle of a locked read stream.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h40, 0, 1);
    #1 check("rst pre l_gnt", {31'b0, l_gnt}, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 1);
    #1 check("rst pre l_rvalid", {31'b0, l_rvalid}, 1);
    check("rst pre l_rdata", l_rdata, 32'h1234);
    #2 rst_n = 1'b0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("rst l_rvalid", {31'b0, l_rvalid}, 0);
    check("rst c_rvalid", {31'b0, c_rvalid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst rel l_rvalid", {31'b0, l_rvalid}, 0);

    // Contention after reset: lock must be gone; C first in both builds.
    prev_v = 1'b0;
    prev_l = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) drive(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_RR_EN
      e_lg = (k < 4) && (k % 2 == 1);
`else
      e_lg = 1'b0;
`endif
      e_cg = (k < 4) && !e_lg;
      #1;
      check($sformatf("post%0d c_gnt", k),    {31'b0, c_gnt},    {31'b0, e_cg});
      check($sformatf("post%0d l_gnt", k),    {31'b0, l_gnt},    {31'b0, e_lg});
      check($sformatf("post%0d c_rvalid", k), {31'b0, c_rvalid}, {31'b0, prev_v && !prev_l});
      check($sformatf("post%0d l_rvalid", k), {31'b0, l_rvalid}, {31'b0, prev_v && prev_l});
      if (prev_v && !prev_l) check($sformatf("post%0d c_rdata", k), c_rdata, 32'hCAFE);
      if (prev_v && prev_l)  check($sformatf("post%0d l_rdata", k), l_rdata, 32'h1234);
      prev_v = e_cg || e_lg;
      prev_l = e_lg;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
